// File: rtl/pipe_pkg.sv
// Shared pipeline types and widths for the ID/EXE register and its hazard detector.
package pipe_pkg;

    localparam int DW  = 32;
    localparam int RW  = 5;
    localparam int CW  = 4;
    localparam int SCW = 16;

    typedef struct packed {
        logic          wb_en;
        logic          mem_r;
        logic          mem_w;
        logic          is_st_br;
        logic [CW-1:0] exe_cmd;
    } id_ctrl_t;

    localparam id_ctrl_t CTRL_BUBBLE = '0;

    typedef enum logic {
        RUN,
        BUBBLE
    } stage_state_t;

    // What the ID/EXE register does on the coming edge.
    typedef enum logic [1:0] {
        SEL_HOLD,
        SEL_FLUSH,
        SEL_STALL,
        SEL_LOAD
    } load_sel_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW / load-use detector comparing the ID sources against EXE and MEM destinations.
module hazard_detect #(
    parameter int RW = pipe_pkg::RW
) (
    input  logic          fwd_en,
    input  logic [RW-1:0] id_src1,
    input  logic [RW-1:0] id_src2,
    input  logic          id_two_src,
    input  logic [RW-1:0] exe_dest,
    input  logic          exe_wb_en,
    input  logic          exe_mem_r,
    input  logic [RW-1:0] mem_dest,
    input  logic          mem_wb_en,
    output logic          hazard
);

    logic match_exe;
    logic match_mem;

    assign match_exe = (id_src1 == exe_dest) || (id_two_src && (id_src2 == exe_dest));
    assign match_mem = (id_src1 == mem_dest) || (id_two_src && (id_src2 == mem_dest));

    // With forwarding only a load in EXE cannot be bypassed; without it every pending writer stalls.
    always_comb begin
        if (fwd_en) begin
            hazard = exe_mem_r && (exe_dest != '0) && match_exe;
        end else begin
            hazard = (exe_wb_en && (exe_dest != '0) && match_exe)
                  || (mem_wb_en && (mem_dest != '0) && match_mem);
        end
    end

endmodule

// File: rtl/id_exe_hazard_reg.sv
// ID/EXE pipeline register with built-in hazard bubble insertion, branch flush and freeze hold.
module id_exe_hazard_reg #(
    parameter int DW  = pipe_pkg::DW,
    parameter int RW  = pipe_pkg::RW,
    parameter int CW  = pipe_pkg::CW,
    parameter int SCW = pipe_pkg::SCW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           freeze,
    input  logic           br_taken,
    input  logic           fwd_en,
    input  logic [RW-1:0]  id_src1,
    input  logic [RW-1:0]  id_src2,
    input  logic           id_two_src,
    input  logic [RW-1:0]  id_dest,
    input  logic           id_wb_en,
    input  logic           id_mem_r,
    input  logic           id_mem_w,
    input  logic           id_is_st_br,
    input  logic [CW-1:0]  id_exe_cmd,
    input  logic [DW-1:0]  id_val1,
    input  logic [DW-1:0]  id_val2,
    input  logic [DW-1:0]  id_st_val,
    input  logic [DW-1:0]  id_pc,
    input  logic [RW-1:0]  mem_dest,
    input  logic           mem_wb_en,
    output logic [RW-1:0]  exe_src1,
    output logic [RW-1:0]  exe_src2,
    output logic [RW-1:0]  exe_dest,
    output logic           exe_wb_en,
    output logic           exe_mem_r,
    output logic           exe_mem_w,
    output logic           exe_is_st_br,
    output logic [CW-1:0]  exe_exe_cmd,
    output logic [DW-1:0]  exe_val1,
    output logic [DW-1:0]  exe_val2,
    output logic [DW-1:0]  exe_st_val,
    output logic [DW-1:0]  exe_pc,
    output logic           exe_valid,
    output logic           hazard_stall,
    output logic [SCW-1:0] stall_cnt
);

    import pipe_pkg::*;

    id_ctrl_t     id_ctrl;
    id_ctrl_t     ctrl_q;
    stage_state_t state;
    stage_state_t next_state;
    load_sel_t    sel;
    logic         hazard;

    assign id_ctrl = '{wb_en: id_wb_en, mem_r: id_mem_r, mem_w: id_mem_w,
                       is_st_br: id_is_st_br, exe_cmd: id_exe_cmd};

    assign exe_wb_en    = ctrl_q.wb_en;
    assign exe_mem_r    = ctrl_q.mem_r;
    assign exe_mem_w    = ctrl_q.mem_w;
    assign exe_is_st_br = ctrl_q.is_st_br;
    assign exe_exe_cmd  = ctrl_q.exe_cmd;

    hazard_detect #(.RW(RW)) u_hazard (
        .fwd_en     (fwd_en),
        .id_src1    (id_src1),
        .id_src2    (id_src2),
        .id_two_src (id_two_src),
        .exe_dest   (exe_dest),
        .exe_wb_en  (ctrl_q.wb_en),
        .exe_mem_r  (ctrl_q.mem_r),
        .mem_dest   (mem_dest),
        .mem_wb_en  (mem_wb_en),
        .hazard     (hazard)
    );

    assign hazard_stall = hazard && !br_taken;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sel        = SEL_LOAD;
        next_state = state;
        if (freeze) begin
            sel = SEL_HOLD;
        end else if (br_taken) begin
            sel = SEL_FLUSH;
        end else if (hazard) begin
            sel = SEL_STALL;
        end

        case (state)
            RUN:     if (sel == SEL_STALL) next_state = BUBBLE;
            BUBBLE:  if ((sel == SEL_FLUSH) || (sel == SEL_LOAD)) next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q     <= CTRL_BUBBLE;
            exe_src1   <= '0;
            exe_src2   <= '0;
            exe_dest   <= '0;
            exe_val1   <= '0;
            exe_val2   <= '0;
            exe_st_val <= '0;
            exe_pc     <= '0;
            exe_valid  <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            case (sel)
                SEL_LOAD: begin
                    ctrl_q     <= id_ctrl;
                    exe_src1   <= id_src1;
                    exe_src2   <= id_src2;
                    exe_dest   <= id_dest;
                    exe_val1   <= id_val1;
                    exe_val2   <= id_val2;
                    exe_st_val <= id_st_val;
                    exe_pc     <= id_pc;
                    exe_valid  <= 1'b1;
                end
                SEL_FLUSH, SEL_STALL: begin
                    ctrl_q     <= CTRL_BUBBLE;
                    exe_src1   <= '0;
                    exe_src2   <= '0;
                    exe_dest   <= '0;
                    exe_val1   <= '0;
                    exe_val2   <= '0;
                    exe_st_val <= '0;
                    exe_pc     <= '0;
                    exe_valid  <= 1'b0;
                    // A flush that coincides with a hazard is not counted as a stall.
                    if ((sel == SEL_STALL) && (stall_cnt != '1)) begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_id_exe_hazard_reg.sv
// Directed, table-driven bench for id_exe_hazard_reg: load-use, no-forwarding, $0, flush, freeze, reset, saturation.
module tb_id_exe_hazard_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze, br_taken, fwd_en;
    logic [4:0]  id_src1, id_src2, id_dest, mem_dest;
    logic        id_two_src, id_wb_en, id_mem_r, id_mem_w, id_is_st_br, mem_wb_en;
    logic [3:0]  id_exe_cmd;
    logic [31:0] id_val1, id_val2, id_st_val, id_pc;
    logic [4:0]  exe_src1, exe_src2, exe_dest;
    logic        exe_wb_en, exe_mem_r, exe_mem_w, exe_is_st_br, exe_valid, hazard_stall;
    logic [3:0]  exe_exe_cmd;
    logic [31:0] exe_val1, exe_val2, exe_st_val, exe_pc;
    logic [15:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_exe_hazard_reg dut (
        .clk(clk), .rst(rst), .freeze(freeze), .br_taken(br_taken), .fwd_en(fwd_en),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_r(id_mem_r), .id_mem_w(id_mem_w), .id_is_st_br(id_is_st_br),
        .id_exe_cmd(id_exe_cmd), .id_val1(id_val1), .id_val2(id_val2), .id_st_val(id_st_val),
        .id_pc(id_pc), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
        .exe_mem_r(exe_mem_r), .exe_mem_w(exe_mem_w), .exe_is_st_br(exe_is_st_br),
        .exe_exe_cmd(exe_exe_cmd), .exe_val1(exe_val1), .exe_val2(exe_val2),
        .exe_st_val(exe_st_val), .exe_pc(exe_pc), .exe_valid(exe_valid),
        .hazard_stall(hazard_stall), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic        br, fwd;
        logic [4:0]  src1, src2;
        logic        two;
        logic [4:0]  dest;
        logic        wb, mr, mw, stbr;
        logic [31:0] val1;
        logic [4:0]  md;
        logic        mwb;
        logic        exp_stall, exp_valid;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic br, fwd, input logic [4:0] src1, src2, input logic two,
                                input logic [4:0] dest, input logic wb, mr, mw, stbr,
                                input logic [31:0] val1, input logic [4:0] md, input logic mwb,
                                input logic exp_stall, exp_valid, input logic [15:0] exp_cnt);
        vec_t v;
        v.br = br; v.fwd = fwd; v.src1 = src1; v.src2 = src2; v.two = two; v.dest = dest;
        v.wb = wb; v.mr = mr; v.mw = mw; v.stbr = stbr; v.val1 = val1; v.md = md; v.mwb = mwb;
        v.exp_stall = exp_stall; v.exp_valid = exp_valid; v.exp_cnt = exp_cnt;
        return v;
    endfunction

    // Expected EXE bundle once a vector's ID instruction has been loaded; derived fields mirror drive().
    function automatic logic [150:0] bundle_of(input vec_t v);
        logic [3:0] cmd;
        cmd = v.dest[3:0] + 4'd1;
        return {v.src1, v.src2, v.dest, v.wb, v.mr, v.mw, v.stbr, cmd,
                v.val1, v.val1 + 32'd1, v.val1 + 32'd2, v.val1 + 32'd3};
    endfunction

    function automatic logic [150:0] exe_bundle();
        return {exe_src1, exe_src2, exe_dest, exe_wb_en, exe_mem_r, exe_mem_w, exe_is_st_br,
                exe_exe_cmd, exe_val1, exe_val2, exe_st_val, exe_pc};
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        br_taken   = v.br;      fwd_en   = v.fwd;
        id_src1    = v.src1;    id_src2  = v.src2;   id_two_src  = v.two;  id_dest = v.dest;
        id_wb_en   = v.wb;      id_mem_r = v.mr;     id_mem_w    = v.mw;   id_is_st_br = v.stbr;
        id_exe_cmd = v.dest[3:0] + 4'd1;
        id_val1    = v.val1;    id_val2  = v.val1 + 32'd1;
        id_st_val  = v.val1 + 32'd2;    id_pc = v.val1 + 32'd3;
        mem_dest   = v.md;      mem_wb_en = v.mwb;
    endtask

    // One cycle: drive, check combinational stall, clock, then check registered outputs.
    task automatic apply(input string name, input vec_t v);
        drive(v);
        #1;
        check({name, ".stall"}, 160'(hazard_stall), 160'(v.exp_stall));
        @(posedge clk);
        #1;
        check({name, ".valid"}, 160'(exe_valid), 160'(v.exp_valid));
        check({name, ".cnt"}, 160'(stall_cnt), 160'(v.exp_cnt));
        check({name, ".bundle"}, 160'(exe_bundle()), v.exp_valid ? 160'(bundle_of(v)) : 160'd0);
    endtask

    initial begin
        vec_t   v;
        vec_t   frozen;
        logic   reached;

        rst = 1'b0; freeze = 1'b0;
        drive(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        //        br fwd s1  s2 two dst wb mr mw sb  val1  md mwb  stl vld cnt
        vq.push_back(mk(0, 1,  1,  0, 0,  3, 1, 1, 0, 0,  100, 0, 0,  0, 1, 0));  // lw $3
        vq.push_back(mk(0, 1,  3,  4, 1,  5, 1, 0, 0, 0,  200, 0, 0,  1, 0, 1));  // add $5,$3,$4: load-use
        vq.push_back(mk(0, 1,  3,  4, 1,  5, 1, 0, 0, 0,  200, 0, 0,  0, 1, 1));
        vq.push_back(mk(0, 0,  0,  0, 0,  2, 1, 0, 0, 0,  300, 0, 0,  0, 1, 1));  // addi $2, no fwd
        vq.push_back(mk(0, 0,  2,  0, 0,  6, 1, 0, 0, 0,  400, 0, 0,  1, 0, 2));  // EXE match
        vq.push_back(mk(0, 0,  2,  0, 0,  6, 1, 0, 0, 0,  400, 2, 1,  1, 0, 3));  // MEM match
        vq.push_back(mk(0, 0,  2,  0, 0,  6, 1, 0, 0, 0,  400, 0, 0,  0, 1, 3));
        vq.push_back(mk(0, 1,  7,  0, 0,  0, 1, 1, 0, 0,  500, 0, 0,  0, 1, 3));  // lw $0
        vq.push_back(mk(0, 1,  0,  0, 0,  8, 1, 0, 0, 0,  600, 0, 0,  0, 1, 3));  // reads $0: no hazard
        vq.push_back(mk(0, 1,  1,  0, 0,  3, 1, 1, 0, 0,  700, 0, 0,  0, 1, 3));  // lw $3
        vq.push_back(mk(1, 1,  3,  4, 1,  5, 1, 0, 0, 0,  800, 0, 0,  0, 0, 3));  // branch masks hazard
        vq.push_back(mk(0, 1,  1,  0, 0,  9, 1, 1, 0, 0,  900, 0, 0,  0, 1, 3));  // lw $9
        vq.push_back(mk(0, 1,  4,  9, 1, 10, 1, 0, 0, 0, 1000, 0, 0,  1, 0, 4));  // src2 load-use
        vq.push_back(mk(0, 1,  4,  9, 1, 10, 1, 0, 0, 0, 1000, 0, 0,  0, 1, 4));
        vq.push_back(mk(0, 1,  1,  0, 0, 11, 1, 1, 0, 0, 1100, 0, 0,  0, 1, 4));  // lw $11
        vq.push_back(mk(0, 1,  4, 11, 0, 12, 1, 0, 1, 0, 1200, 0, 0,  0, 1, 4));  // src2 not a register
        vq.push_back(mk(0, 1, 12,  0, 0, 13, 1, 0, 0, 1, 1300, 0, 0,  0, 1, 4));  // ALU result forwarded

        #2;
        check("reset.valid", 160'(exe_valid), 160'd0);
        check("reset.cnt", 160'(stall_cnt), 160'd0);
        check("reset.bundle", 160'(exe_bundle()), 160'd0);
        check("reset.stall", 160'(hazard_stall), 160'd0);
        #10 rst = 1'b1;

        foreach (vq[i]) apply($sformatf("vec%0d", i), vq[i]);

        // Freeze: EXE holds for three edges while ID changes, a hazard shows and a branch arrives.
        frozen = vq[vq.size() - 1];
        freeze = 1'b1;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       v = mk(0, 0, 13, 0, 0, 14, 1, 0, 0, 0, 1400, 0, 0, 1, 0, 0);
                1:       v = mk(1, 1, 15, 0, 0, 15, 1, 0, 0, 0, 1500, 0, 0, 0, 0, 0);
                default: v = mk(1, 1, 20, 0, 0, 21, 1, 0, 0, 0, 2100, 0, 0, 0, 0, 0);
            endcase
            drive(v);
            #1;
            check($sformatf("freeze%0d.stall", k), 160'(hazard_stall), 160'(v.exp_stall));
            @(posedge clk);
            #1;
            check($sformatf("freeze%0d.bundle", k), 160'(exe_bundle()), 160'(bundle_of(frozen)));
            check($sformatf("freeze%0d.valid", k), 160'(exe_valid), 160'd1);
            check($sformatf("freeze%0d.cnt", k), 160'(stall_cnt), 160'd4);
        end
        freeze = 1'b0;
        apply("unfreeze", mk(0, 1, 20, 0, 0, 21, 1, 0, 0, 0, 2100, 0, 0, 0, 1, 4));

        // Asynchronous reset while a load-use stall is being requested.
        apply("rst_lw", mk(0, 1, 1, 0, 0, 3, 1, 1, 0, 0, 3000, 0, 0, 0, 1, 4));
        v = mk(0, 1, 3, 4, 1, 5, 1, 0, 0, 0, 3100, 0, 0, 1, 1, 0);
        drive(v);
        #1;
        check("rst_mid.stall_before", 160'(hazard_stall), 160'd1);
        rst = 1'b0;
        #1;
        check("rst_mid.valid", 160'(exe_valid), 160'd0);
        check("rst_mid.cnt", 160'(stall_cnt), 160'd0);
        check("rst_mid.bundle", 160'(exe_bundle()), 160'd0);
        check("rst_mid.stall", 160'(hazard_stall), 160'd0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_after.valid", 160'(exe_valid), 160'd1);
        check("rst_after.bundle", 160'(exe_bundle()), 160'(bundle_of(v)));
        check("rst_after.cnt", 160'(stall_cnt), 160'd0);

        // Saturation: a persistent MEM-stage hazard with forwarding off bubbles every edge.
        drive(mk(0, 0, 2, 0, 0, 6, 1, 0, 0, 0, 4000, 2, 1, 1, 0, 0));
        reached = 1'b0;
        for (int c = 0; c < 70000; c++) begin
            @(posedge clk);
            #1;
            if (stall_cnt == 16'hffff) begin
                reached = 1'b1;
                break;
            end
        end
        check("sat.reached", 160'(reached), 160'd1);
        repeat (3) @(posedge clk);
        #1;
        check("sat.hold", 160'(stall_cnt), 160'hffff);
        check("sat.valid", 160'(exe_valid), 160'd0);
        check("sat.stall", 160'(hazard_stall), 160'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_exe_hazard_reg.md
Name: id_exe_hazard_reg

Overview:
- ID/EXE pipeline register for the 5-stage MIPS pipeline, with the load-use / RAW hazard detector built in.
- Registers the decoded ID-stage instruction into the EXE stage and drives the forwarding unit's inputs: src1, src2, Dest_exe, is_st_br.
- Inserts a bubble on a hazard, flushes on a taken branch, and holds on a pipeline freeze.
- Raises hazard_stall so the PC and IF/ID stages hold.

Parameters:
- DW, 32, data/PC width
- RW, 5, register-index width
- CW, 4, EXE command width
- SCW, 16, stall-counter width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- freeze  in  1  global hold, e.g. memory wait
- br_taken  in  1  branch resolved taken in EXE; flush the ID instruction
- fwd_en  in  1  forwarding enabled
- id_src1, id_src2  in  RW  ID source register indices
- id_two_src  in  1  ID instruction reads src2 as a register
- id_dest  in  RW  ID destination register
- id_wb_en, id_mem_r, id_mem_w, id_is_st_br  in  1  ID control bits
- id_exe_cmd  in  CW  ALU command
- id_val1, id_val2, id_st_val, id_pc  in  DW  ID operand values and PC
- mem_dest  in  RW  MEM-stage destination
- mem_wb_en  in  1  MEM-stage write-back enable
- exe_src1, exe_src2, exe_dest  out  RW  registered indices (to forwarding unit)
- exe_wb_en, exe_mem_r, exe_mem_w, exe_is_st_br  out  1  registered control
- exe_exe_cmd  out  CW  registered ALU command
- exe_val1, exe_val2, exe_st_val, exe_pc  out  DW  registered values
- exe_valid  out  1  EXE holds a real instruction, not a bubble
- hazard_stall  out  1  combinational: hold PC and IF/ID
- stall_cnt  out  SCW  saturating count of hazard bubbles

Behaviour:
- Reset (rst=0, asynchronous): all exe_* outputs = 0, exe_valid = 0, stall_cnt = 0, state = RUN.
- Latency: one cycle from ID inputs to exe_* outputs.
- Let m1 = (id_src1 == X), m2 = id_two_src && (id_src2 == X), where X is the destination being checked. Register 0 never matches.
- Hazard, combinational, when fwd_en=1: exe_mem_r && exe_dest != 0 && (m1 || m2) with X = exe_dest.
- Hazard, combinational, when fwd_en=0: any of the following.
  - exe_wb_en && exe_dest != 0 && match with X = exe_dest.
  - mem_wb_en && mem_dest != 0 && match with X = mem_dest.
- hazard_stall = hazard && !br_taken. A taken branch masks the stall.
- Per-edge priority, highest first:
  - freeze=1: every register holds, including state and stall_cnt. hazard_stall is still computed.
  - br_taken=1: load a bubble.
  - hazard=1: load a bubble, stall_cnt += 1 (saturating at all-ones), state -> BUBBLE.
  - otherwise: load every id_* field, exe_valid = 1, state -> RUN.
- Bubble definition:
  - exe_wb_en, exe_mem_r, exe_mem_w, exe_is_st_br, exe_valid = 0.
  - exe_dest, exe_src1, exe_src2 = 0.
  - Data fields and exe_exe_cmd = 0.
- FSM:
  - RUN: normal operation.
  - BUBBLE: the last loaded slot was a hazard bubble.
  - BUBBLE -> RUN on the next non-frozen edge without a hazard. BUBBLE -> BUBBLE if the hazard persists (fwd_en=0 can give 2 consecutive bubbles).
  - State is observable only through exe_valid and stall_cnt; no separate output.
- Simultaneous br_taken and hazard: flush wins, stall_cnt unchanged, hazard_stall = 0.
- Simultaneous freeze and br_taken: hold. The branch owner keeps br_taken asserted until the freeze drops.
- Reset asserted mid-stall: immediate clear, and hazard_stall falls with it because the exe_* terms go to 0.
- stall_cnt at 2^SCW-1: holds.

Decomposition:
- Shared package pipe_pkg:
  - RW, DW, CW constants.
  - Bubble constant for the control bundle.
  - typedef id_ctrl_t {wb_en, mem_r, mem_w, is_st_br, exe_cmd}.
- One sub-module, hazard_detect: purely combinational, outputs hazard, instantiated inside.

Test Plan:
1. Load-use with fwd_en=1:
   - Stimulus: lw $3 in EXE (exe_mem_r=1, exe_dest=3), then ID add $5,$3,$4.
   - Required: hazard_stall=1 for 1 cycle; next edge exe_valid=0 and stall_cnt=1; following edge exe_src1=3 and exe_valid=1.
2. No forwarding (fwd_en=0):
   - Stimulus: addi $2 in EXE (exe_wb_en=1, exe_dest=2), ID reads $2.
   - Required: 2 consecutive bubbles (EXE match, then MEM match with mem_dest=2); stall_cnt=2.
3. Register zero:
   - Stimulus: exe_mem_r=1, exe_dest=0, id_src1=0.
   - Required: hazard_stall=0; instruction loads normally.
4. Branch and hazard together:
   - Stimulus: br_taken=1 with the case-1 hazard.
   - Required: hazard_stall=0, bubble loaded, stall_cnt unchanged.
5. Freeze:
   - Stimulus: freeze=1 for 3 cycles with changing id_* values.
   - Required: exe_* constant; on release the current id_* values load.
6. Reset mid-bubble:
   - Stimulus: drop rst asynchronously between edges.
   - Required: all outputs 0 immediately; stall_cnt=0; first edge after rst=1 loads the ID instruction.
